// File: rtl/packer.sv
// -----------------------------------------------------------------------------
// packer
//
// Packs a stream of narrow beats (INPUT_WIDTH bits each) into wide output
// words (OUTPUT_WIDTH bits, MAX_CNT lanes). The first beat of a word lands in
// lane 0 (bits [INPUT_WIDTH-1:0]). A word is emitted when all lanes are filled
// or when a beat arrives with in_last set. Unfilled lanes are zero and are
// flagged as invalid in out_keep. OUTPUT_WIDTH must be an integer multiple of
// INPUT_WIDTH.
//
// The output register supports zero-bubble operation. A new word may replace
// the one being transferred in the same cycle, so with out_ready held high the
// packer sustains one beat per cycle.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous discard of all held data (highest priority)
//   in_data    in   narrow data beat
//   in_valid   in   in_data valid
//   in_last    in   beat closes a stream (qualified by in_valid)
//   in_ready   out  beat is accepted this cycle when in_valid is high
//   out_data   out  packed word (registered)
//   out_keep   out  per-lane valid mask
//   out_last   out  word closes a stream
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts word
//   word_cnt   out  output words transferred since reset/clear (wraps)
// -----------------------------------------------------------------------------
module packer #(
  parameter int INPUT_WIDTH  = 64,
  parameter int OUTPUT_WIDTH = 512,
  parameter int MAX_CNT      = OUTPUT_WIDTH / INPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic [MAX_CNT-1:0]      out_keep,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             word_cnt
);

  localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(MAX_CNT - 1);

  // FILL collects beats. FLUSH holds a finished partial word (always a stream
  // end) until the output register frees up. No beats are accepted in FLUSH.
  typedef enum logic {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
  logic [MAX_CNT-1:0]      mask_q, mask_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [MAX_CNT-1:0]      out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
  logic [15:0]             word_cnt_q, word_cnt_d;

  logic                    out_free;
  logic                    accept;
  logic                    xfer;
  logic                    completing;
  logic [OUTPUT_WIDTH-1:0] acc_lane;
  logic [MAX_CNT-1:0]      mask_lane;
  logic                    load;
  logic [OUTPUT_WIDTH-1:0] load_data;
  logic [MAX_CNT-1:0]      load_keep;
  logic                    load_last;

  // The output slot can take a new word if it is empty or is being drained
  // this very cycle.
  assign out_free   = !out_valid_q || out_ready;
  assign in_ready   = (state_q == S_FILL) && ((cnt_q != LAST_LANE) || out_free);
  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid_q && out_ready;
  assign completing = accept && ((cnt_q == LAST_LANE) || in_last);

  // Accumulator and mask with the current beat merged into lane cnt.
  always_comb begin
    acc_lane  = acc_q;
    mask_lane = mask_q;
    acc_lane[int'(cnt_q) * INPUT_WIDTH +: INPUT_WIDTH] = in_data;
    mask_lane[cnt_q] = 1'b1;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !xfer;
    word_cnt_d  = xfer ? word_cnt_q + 16'd1 : word_cnt_q;
    load        = 1'b0;
    load_data   = acc_lane;
    load_keep   = mask_lane;
    load_last   = in_last;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          if (!completing) begin
            acc_d  = acc_lane;
            mask_d = mask_lane;
            cnt_d  = cnt_q + CNT_W'(1);
          end else if (out_free) begin
            load = 1'b1;
          end else begin
            // Stream ended early while the previous word is still stalled.
            // Park the partial word; it goes out as a stream end later.
            acc_d   = acc_lane;
            mask_d  = mask_lane;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = acc_q;
          load_keep = mask_q;
          load_last = 1'b1;
          state_d   = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase

    if (load) begin
      out_data_d  = load_data;
      out_keep_d  = load_keep;
      out_last_d  = load_last;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      acc_d       = '0;
      mask_d      = '0;
    end

    // clear wins over everything, including a beat or transfer this cycle.
    // out_data is not cleared; out_valid low makes it meaningless.
    if (clear) begin
      state_d     = S_FILL;
      cnt_d       = '0;
      acc_d       = '0;
      mask_d      = '0;
      out_keep_d  = '0;
      out_last_d  = 1'b0;
      out_valid_d = 1'b0;
      word_cnt_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; next-state logic above uses blocking assignments.
  // NOTE: the accumulator is a plain register bank, not a memory, so it is
  // reset like the rest; a reset mid-stream must drop any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_packer.sv
// -----------------------------------------------------------------------------
// tb_packer
//
// Self-checking bench for packer with default parameters (64-bit lanes,
// 512-bit words, 8 lanes). A table of per-cycle records gives the inputs for
// one clock and the outputs expected right after that clock edge; in_ready is
// compared before the edge since it is combinational. Back-to-back throughput
// and a reset in the middle of a word are checked by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_packer;

  localparam int IW = 64;
  localparam int OW = 512;
  localparam int NL = 8;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic [NL-1:0] out_keep;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   word_cnt;

  packer #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .MAX_CNT     (NL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            clr;
    bit            vld;
    logic [IW-1:0] data;
    bit            lst;
    bit            ordy;
    bit            exp_rdy;
    bit            exp_ov;
    logic [15:0]   exp_wc;
    bit            chk_kl;
    logic [NL-1:0] exp_keep;
    bit            exp_last;
    bit            chk_d;
    logic [OW-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word whose lane i holds base+i for i < n, zero above.
  function automatic logic [OW-1:0] mk(input logic [IW-1:0] base, input int n);
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < NL; i++)
      if (i < n) w[i*IW +: IW] = base + IW'(i);
    return w;
  endfunction

  function automatic void add(input bit clr, input bit vld, input logic [IW-1:0] d,
                              input bit lst, input bit ordy, input bit rdy,
                              input bit ov, input logic [15:0] wc, input bit chk_kl,
                              input logic [NL-1:0] keep, input bit ol,
                              input bit chk_d, input logic [OW-1:0] ed);
    vec_t v;
    v.clr = clr; v.vld = vld; v.data = d; v.lst = lst; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_wc = wc;
    v.chk_kl = chk_kl; v.exp_keep = keep; v.exp_last = ol;
    v.chk_d = chk_d; v.exp_data = ed;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    clear     = v.clr;
    in_valid  = v.vld;
    in_data   = v.data;
    in_last   = v.lst;
    out_ready = v.ordy;
    #1;
    check({tag, ".in_ready"}, OW'(in_ready), OW'(v.exp_rdy));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, OW'(out_valid), OW'(v.exp_ov));
    check({tag, ".word_cnt"}, OW'(word_cnt), OW'(v.exp_wc));
    if (v.chk_kl) begin
      check({tag, ".out_keep"}, OW'(out_keep), OW'(v.exp_keep));
      check({tag, ".out_last"}, OW'(out_last), OW'(v.exp_last));
    end
    if (v.chk_d) check({tag, ".out_data"}, out_data, v.exp_data);
  endtask

  function automatic void build_table();
    // Eight beats, lane value = index, full word one cycle after beat 8.
    for (int i = 0; i < 8; i++)
      add(0, 1, IW'(i), 0, 1, 1, i == 7, 0, i == 7, 8'hFF, 0, i == 7, mk(0, 8));
    // Transfer with nothing new: valid drops, word fields hold.
    add(0, 0, 0, 0, 1, 1, 0, 1, 1, 8'hFF, 0, 1, mk(0, 8));

    // Short stream of three beats: zero-padded, keep 0x07, last set.
    for (int i = 0; i < 3; i++)
      add(0, 1, IW'(8'h10 + i), i == 2, 1, 1, i == 2, 1, i == 2, 8'h07, 1, i == 2,
          mk(8'h10, 3));
    add(0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0, '0);

    // in_last on the final lane: full word with last set.
    for (int i = 0; i < 8; i++)
      add(0, 1, IW'(8'hA0 + i), i == 7, 1, 1, i == 7, 2, i == 7, 8'hFF, 1, i == 7,
          mk(8'hA0, 8));
    add(0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0, '0);

    // Word held by backpressure, then a two-beat stream ends: FLUSH.
    for (int i = 0; i < 8; i++)
      add(0, 1, IW'(8'h20 + i), 0, 0, 1, i == 7, 3, i == 7, 8'hFF, 0, i == 7,
          mk(8'h20, 8));
    add(0, 1, IW'(8'h30), 0, 0, 1, 1, 3, 1, 8'hFF, 0, 1, mk(8'h20, 8));
    add(0, 1, IW'(8'h31), 1, 0, 1, 1, 3, 1, 8'hFF, 0, 1, mk(8'h20, 8));
    add(0, 0, 0, 0, 0, 0, 1, 3, 1, 8'hFF, 0, 1, mk(8'h20, 8));
    // Beat offered in FLUSH is refused; held word goes, flush word loads.
    add(0, 1, IW'(8'h99), 0, 1, 0, 1, 4, 1, 8'h03, 1, 1, mk(8'h30, 2));
    add(0, 0, 0, 0, 0, 1, 1, 4, 1, 8'h03, 1, 1, mk(8'h30, 2));
    add(0, 0, 0, 0, 1, 1, 0, 5, 1, 8'h03, 1, 1, mk(8'h30, 2));

    // cnt at last lane with the output stalled: in_ready low, word stable,
    // then same-cycle replacement when out_ready returns.
    for (int i = 0; i < 8; i++)
      add(0, 1, IW'(8'h50 + i), 0, 1, 1, i == 7, 5, i == 7, 8'hFF, 0, i == 7,
          mk(8'h50, 8));
    for (int i = 0; i < 7; i++)
      add(0, 1, IW'(8'h60 + i), 0, 0, 1, 1, 5, 1, 8'hFF, 0, 1, mk(8'h50, 8));
    add(0, 1, IW'(8'h67), 0, 0, 0, 1, 5, 1, 8'hFF, 0, 1, mk(8'h50, 8));
    add(0, 1, IW'(8'h67), 0, 1, 1, 1, 6, 1, 8'hFF, 0, 1, mk(8'h60, 8));
    add(0, 0, 0, 0, 1, 1, 0, 7, 0, 0, 0, 0, '0);

    // clear at cnt=5 with a word pending; the transfer in that cycle is lost.
    for (int i = 0; i < 8; i++)
      add(0, 1, IW'(8'h80 + i), 0, 1, 1, i == 7, 7, i == 7, 8'hFF, 0, i == 7,
          mk(8'h80, 8));
    for (int i = 0; i < 5; i++)
      add(0, 1, IW'(8'h70 + i), 0, 0, 1, 1, 7, 1, 8'hFF, 0, 1, mk(8'h80, 8));
    add(1, 1, IW'(8'hEE), 0, 1, 1, 0, 0, 1, 8'h00, 0, 0, '0);
    for (int i = 0; i < 8; i++)
      add(0, 1, IW'(8'h90 + i), 0, 1, 1, i == 7, 0, i == 7, 8'hFF, 0, i == 7,
          mk(8'h90, 8));
    add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, '0);
  endfunction

  initial begin
    vec_t v;
    rst_n = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    build_table();

    repeat (3) @(negedge clk);
    check("rst.out_valid", OW'(out_valid), OW'(0));
    check("rst.out_data", out_data, '0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", OW'(in_ready), OW'(1));
    check("rst.word_cnt", OW'(word_cnt), OW'(0));
    check("rst.out_keep", OW'(out_keep), OW'(0));
    check("rst.out_last", OW'(out_last), OW'(0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // 16 back-to-back beats: in_ready never drops, words 8 cycles apart.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b1; in_data = IW'(8'hB0 + i);
      in_last = 1'b0; out_ready = 1'b1;
      #1;
      check($sformatf("b2b%0d.in_ready", i), OW'(in_ready), OW'(1));
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d.out_valid", i), OW'(out_valid),
            OW'((i == 7) || (i == 15)));
      if (i == 7)  check("b2b7.out_data", out_data, mk(8'hB0, 8));
      if (i == 15) check("b2b15.out_data", out_data, mk(8'hB8, 8));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b.word_cnt", OW'(word_cnt), OW'(3));

    // Reset in the middle of a word: partial data is discarded.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = IW'(8'hD0 + i); in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst.out_valid", OW'(out_valid), OW'(0));
    check("midrst.word_cnt", OW'(word_cnt), OW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v.clr = 0; v.vld = 1; v.data = IW'(8'hC0 + i); v.lst = (i == 4); v.ordy = 1;
      v.exp_rdy = 1; v.exp_ov = (i == 4); v.exp_wc = 0;
      v.chk_kl = (i == 4); v.exp_keep = 8'h1F; v.exp_last = 1;
      v.chk_d = (i == 4); v.exp_data = mk(8'hC0, 5);
      apply(v, $sformatf("post%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/packer.md
PACKER -- requirements
Module: packer

Interface
REQ-001 Parameter INPUT_WIDTH, default 64, width of one narrow input beat (one lane).
REQ-002 Parameter OUTPUT_WIDTH, default 512, width of one packed output word.
REQ-003 Parameter MAX_CNT, default OUTPUT_WIDTH/INPUT_WIDTH, lanes per output word; OUTPUT_WIDTH SHALL be an integer multiple of INPUT_WIDTH.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous discard of all held data; higher priority than every other event.
REQ-007 in_data  input  INPUT_WIDTH  narrow data beat.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_last  input  1  beat is final of a stream; qualified by in_valid.
REQ-010 in_ready  output  1  packer accepts beat this cycle.
REQ-011 out_data  output  OUTPUT_WIDTH  packed word, registered.
REQ-012 out_keep  output  MAX_CNT  per-lane valid mask, bit i covers out_data[i*INPUT_WIDTH +: INPUT_WIDTH].
REQ-013 out_last  output  1  word ends a stream.
REQ-014 out_valid  output  1  output word valid.
REQ-015 out_ready  input  1  downstream accepts word.
REQ-016 word_cnt  output  16  count of output words transferred since reset/clear, wraps 0xFFFF->0.

Function
REQ-017 Accepted beat = in_valid && in_ready; output transfer = out_valid && out_ready.
REQ-018 Lane index cnt, range 0..MAX_CNT-1; accepted beat SHALL be written into accumulator lane cnt (first beat at bits [INPUT_WIDTH-1:0]).
REQ-019 out_free = !out_valid || out_ready (combinational).
REQ-020 in_ready = !flush_pend && (cnt != MAX_CNT-1 || out_free); SHALL NOT depend on in_valid or in_last.
REQ-021 Completing beat = accepted beat with cnt == MAX_CNT-1 or in_last == 1.
REQ-022 Non-completing accepted beat: store lane, cnt <= cnt+1, keep bit cnt set; no output change.
REQ-023 Completing beat with out_free: next edge out_data <= accumulator incl. current lane, unfilled lanes zero, out_keep <= filled-lane mask, out_last <= in_last, out_valid <= 1, cnt <= 0, accumulator and mask cleared; latency 1 cycle from accepting edge.
REQ-024 Completing beat with !out_free (only possible via in_last at cnt < MAX_CNT-1): store lane, enter state FLUSH (flush_pend <= 1, last_pend <= 1).
REQ-025 States: FILL (flush_pend=0) and FLUSH (flush_pend=1); FLUSH -> FILL on first cycle with out_free, loading output per REQ-023 with out_last <= 1; no beats accepted in FLUSH.
REQ-026 Output transfer with no new load in same cycle: out_valid <= 0; out_data/out_keep/out_last hold value.
REQ-027 Simultaneous output transfer and new load: new word SHALL replace old with out_valid staying 1; zero bubble, full throughput of 1 beat/cycle at out_ready=1.
REQ-028 out_data, out_keep, out_last SHALL remain stable while out_valid && !out_ready.
REQ-029 word_cnt increments by 1 on each output transfer.
REQ-030 in_last at cnt == MAX_CNT-1 produces full word, out_keep all ones, out_last 1.
REQ-031 clear: next edge cnt, accumulator, mask, flush_pend, out_valid, out_keep, out_last, word_cnt <= 0; beat/transfer in clear cycle is dropped/not counted.

Reset
REQ-032 rst_n low asynchronously forces out_data 0, out_keep 0, out_last 0, out_valid 0, word_cnt 0, cnt 0, flush_pend 0, accumulator 0; in_ready SHALL be 1 in first cycle after reset release.
REQ-033 Reset mid-stream SHALL discard partial words with no output emitted.

Verification
REQ-034 8 beats 0x00..07 (lane value = index), out_ready=1 -> one word, lane i = i, out_keep 0xFF, out_last 0, out_valid 1 cycle after 8th beat, word_cnt 1.
REQ-035 16 back-to-back beats, out_ready=1 -> two words on consecutive-8-cycle spacing, in_ready never low, word_cnt 2.
REQ-036 3 beats A,B,C with in_last on C, out_ready=1 -> lanes 0..2 = A,B,C, lanes 3..7 zero, out_keep 0x07, out_last 1.
REQ-037 Word held (out_ready=0), then 2 beats with in_last on 2nd -> FLUSH entered, in_ready 0; out_ready=1 -> first word transfers, next cycle out_keep 0x03, out_last 1, in_ready 1.
REQ-038 cnt=7 with out_valid=1, out_ready=0 -> in_ready 0, out_data stable; out_ready=1 -> beat accepted, same-cycle replacement per REQ-027.
REQ-039 clear asserted at cnt=5 with word pending -> out_valid 0, word_cnt 0, next 8 beats form a fresh word starting at lane 0.
